// File: rtl/lcd_spi_writer_if.sv
// Handshake between the LCD init/draw sequencer and the SPI writer:
// word request/level, 9-bit command/data word, per-byte completion and busy.
interface lcd_spi_writer_if;
    logic       en_write;
    logic [8:0] init_data;
    logic       wr_done;
    logic       busy;

    modport master (
        output en_write,
        output init_data,
        input  wr_done,
        input  busy
    );

    modport slave (
        input  en_write,
        input  init_data,
        output wr_done,
        output busy
    );
endinterface

// File: rtl/lcd_spi_writer.sv
// Mode-0 SPI serialiser for 9-bit LCD command/data words, one wr_done pulse per byte.
// Optional build macro LCD_SPI_CS_TOGGLE_EN: release lcd_cs during the inter-byte gap.
module lcd_spi_writer #(
    parameter int SCLK_DIV = 2,
    parameter int GAP      = 4
) (
    input  logic              sys_clk_50MHz,
    input  logic              sys_rst_n,
    lcd_spi_writer_if.slave   bus,
    output logic              lcd_cs,
    output logic              lcd_sclk,
    output logic              lcd_mosi,
    output logic              lcd_dc
);

    localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t      state_reg;
    logic [6:0]  shift_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  div_cnt_reg;
    logic [7:0]  gap_cnt_reg;
    logic        cs_reg;
    logic        sclk_reg;
    logic        mosi_reg;
    logic        dc_reg;
    logic        wr_done_reg;
    logic        busy_reg;
    logic        start_load;

    // A new word is taken from IDLE, or at the last gap cycle of the previous byte.
    assign start_load = bus.en_write &&
                        ((state_reg == ST_IDLE) ||
                         ((state_reg == ST_GAP) && (gap_cnt_reg == GAP_LAST)));

    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            cs_reg      <= 1'b1;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            dc_reg      <= 1'b0;
            wr_done_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            wr_done_reg <= 1'b0;
            if (start_load) begin
                state_reg   <= ST_LOAD;
                shift_reg   <= bus.init_data[6:0];
                mosi_reg    <= bus.init_data[7];
                dc_reg      <= bus.init_data[8];
                cs_reg      <= 1'b0;
                sclk_reg    <= 1'b0;
                busy_reg    <= 1'b1;
                bit_cnt_reg <= '0;
                div_cnt_reg <= '0;
                gap_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        cs_reg   <= 1'b1;
                        sclk_reg <= 1'b0;
                    end
                    ST_LOAD: begin
                        state_reg <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (div_cnt_reg == DIV_LAST) begin
                            div_cnt_reg <= '0;
                            if (!sclk_reg) begin
                                sclk_reg <= 1'b1;
                            end else begin
                                sclk_reg <= 1'b0;
                                if (bit_cnt_reg == 3'd7) begin
                                    wr_done_reg <= 1'b1;
                                    gap_cnt_reg <= '0;
                                    state_reg   <= ST_GAP;
`ifdef LCD_SPI_CS_TOGGLE_EN
                                    cs_reg      <= 1'b1;
`else
                                    cs_reg      <= 1'b0;
`endif
                                end else begin
                                    // Next bit goes out on the falling edge, well before the next rise.
                                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                                    mosi_reg    <= shift_reg[6];
                                    shift_reg   <= {shift_reg[5:0], 1'b0};
                                end
                            end
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 8'd1;
                        end
                    end
                    ST_GAP: begin
                        sclk_reg <= 1'b0;
                        if (gap_cnt_reg == GAP_LAST) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            cs_reg    <= 1'b1;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 8'd1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign lcd_cs      = cs_reg;
    assign lcd_sclk    = sclk_reg;
    assign lcd_mosi    = mosi_reg;
    assign lcd_dc      = dc_reg;
    assign bus.wr_done = wr_done_reg;
    assign bus.busy    = busy_reg;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Directed bench for lcd_spi_writer: per-byte vector table, sequencer-driven streams,
// mid-byte reset and chip-select behaviour between consecutive bytes.
module tb_lcd_spi_writer;

    localparam int SCLK_DIV = 2;
    localparam int GAP      = 4;
    localparam int BYTE_LAT = 1 + 16 * SCLK_DIV;   // LOAD edge to wr_done edge
    localparam int PERIOD   = BYTE_LAT + GAP;      // byte-to-byte spacing
    localparam int NSTREAM  = 58;

    logic sys_clk_50MHz = 1'b0;
    logic sys_rst_n     = 1'b0;
    logic lcd_cs, lcd_sclk, lcd_mosi, lcd_dc;

    lcd_spi_writer_if bus ();

    lcd_spi_writer #(.SCLK_DIV(SCLK_DIV), .GAP(GAP)) dut (
        .sys_clk_50MHz (sys_clk_50MHz),
        .sys_rst_n     (sys_rst_n),
        .bus           (bus),
        .lcd_cs        (lcd_cs),
        .lcd_sclk      (lcd_sclk),
        .lcd_mosi      (lcd_mosi),
        .lcd_dc        (lcd_dc)
    );

    always #10 sys_clk_50MHz = ~sys_clk_50MHz;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge sys_clk_50MHz) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Output monitor, sampled on the falling clock edge.
    int   wd_count = 0;
    int   wd_cycs[$];
    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;
    int   mosi_viol = 0;
    bit   cs_win = 1'b0;
    int   cs_high_cnt = 0;

    always @(negedge sys_clk_50MHz) begin
        if (bus.wr_done === 1'b1) begin
            wd_count++;
            wd_cycs.push_back(cyc);
        end
        if (lcd_sclk && prev_sclk && (lcd_mosi !== prev_mosi)) mosi_viol++;
        prev_sclk = lcd_sclk;
        prev_mosi = lcd_mosi;
        if (cs_win && lcd_cs) cs_high_cnt++;
    end

    // Panel-side receiver: samples mosi on each sclk rise, MSB first.
    int         rx_bits  = 0;
    int         rx_rises = 0;
    logic [7:0] rx_sh    = '0;
    logic [8:0] rx_q[$];

    always @(posedge lcd_sclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_bits = 0;
        end else begin
            rx_rises++;
            rx_sh = {rx_sh[6:0], lcd_mosi};
            rx_bits++;
            if (rx_bits == 8) begin
                rx_q.push_back({lcd_dc, rx_sh});
                rx_bits = 0;
            end
        end
    end

    typedef struct {
        logic [8:0] word;
        logic [7:0] exp_byte;
        logic       exp_dc;
    } vec_t;

    vec_t       vecs[6];
    logic [8:0] seq_tbl[64];

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge sys_clk_50MHz); #1;
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, int'(ok), 1);
    endtask

    task automatic send_single(input vec_t v, input int k);
        int t0, n0, r0, lat;
        bit ok;
        @(posedge sys_clk_50MHz); #1;
        n0 = wd_count;
        r0 = rx_rises;
        rx_q.delete();
        wd_cycs.delete();
        bus.init_data = v.word;
        bus.en_write  = 1'b1;
        t0 = cyc;
        repeat (2) @(posedge sys_clk_50MHz);
        #1;
        chk("busy_mid", int'(bus.busy), 1);
        chk("cs_low_mid", int'(lcd_cs), 0);
        bus.init_data = ~v.word;    // must be ignored outside LOAD
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clk_50MHz); #1;
            if (bus.wr_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wr_done_seen", int'(ok), 1);
        bus.en_write = 1'b0;
        wait_idle("idle_after_single");
        // Drive happens one edge before the LOAD edge, hence +1.
        lat = (wd_cycs.size() > 0) ? (wd_cycs[0] - t0) : -1;
        chk("wr_done_latency", lat, BYTE_LAT + 1);
        chk("sclk_rises", rx_rises - r0, 8);
        chk("wr_done_count", wd_count - n0, 1);
        chk("rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            chk("rx_byte", int'(rx_q[0][7:0]), int'(v.exp_byte));
            chk("rx_dc", int'(rx_q[0][8]), int'(v.exp_dc));
            $display("txn %0d: word=%03h rx=%02h dc=%0d latency=%0d", k, v.word, rx_q[0][7:0], rx_q[0][8], lat);
        end
        chk("cs_idle_after", int'(lcd_cs), 1);
    endtask

    // Models the sequencer: index advances on wr_done, data is registered one cycle later,
    // and en_write drops two cycles after the final wr_done.
    task automatic run_stream(input int n);
        int idx, pend;
        bit done;
        rx_q.delete();
        wd_cycs.delete();
        cs_high_cnt = 0;
        @(posedge sys_clk_50MHz); #1;
        idx = 0;
        pend = 0;
        done = 1'b0;
        bus.init_data = seq_tbl[0];
        bus.en_write  = 1'b1;
        for (int c = 0; c < n * (PERIOD + 4) + 100; c++) begin
            @(posedge sys_clk_50MHz); #1;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (idx < n) bus.init_data = seq_tbl[idx];
                    else         bus.en_write  = 1'b0;
                end
            end
            if (bus.wr_done) begin
                idx++;
                pend = 2;
                cs_win = (idx < n);
            end
            if (!bus.en_write && !bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        cs_win = 1'b0;
        chk("stream_done", int'(done), 1);
    endtask

    initial begin
        int n0, viol;
        bit ok;

        vecs[0] = '{word: 9'h011, exp_byte: 8'h11, exp_dc: 1'b0};
        vecs[1] = '{word: 9'h155, exp_byte: 8'h55, exp_dc: 1'b1};
        vecs[2] = '{word: 9'h0FF, exp_byte: 8'hFF, exp_dc: 1'b0};
        vecs[3] = '{word: 9'h100, exp_byte: 8'h00, exp_dc: 1'b1};
        vecs[4] = '{word: 9'h0A5, exp_byte: 8'hA5, exp_dc: 1'b0};
        vecs[5] = '{word: 9'h180, exp_byte: 8'h80, exp_dc: 1'b1};

        bus.en_write  = 1'b0;
        bus.init_data = '0;

        repeat (3) @(posedge sys_clk_50MHz);
        #1;
        chk("reset_outputs", int'({lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, bus.wr_done, bus.busy}), 6'b100000);
        sys_rst_n = 1'b1;

        // Idle with en_write low.
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk_50MHz);
            if ({lcd_cs, lcd_sclk, bus.wr_done, bus.busy} !== 4'b1000) viol++;
        end
        chk("idle_100_cycles", viol, 0);

        for (int k = 0; k < 6; k++) send_single(vecs[k], k);

        // Two data bytes through the sequencer model.
        seq_tbl[0] = 9'h155;
        seq_tbl[1] = 9'h1A4;
        n0 = wd_count;
        run_stream(2);
        repeat (100) @(posedge sys_clk_50MHz);
        #1;
        chk("pair_wr_done_count", wd_count - n0, 2);
        chk("pair_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("pair_rx0", int'(rx_q[0]), 9'h155);
            chk("pair_rx1", int'(rx_q[1]), 9'h1A4);
        end
        if (wd_cycs.size() == 2) chk("pair_spacing", wd_cycs[1] - wd_cycs[0], PERIOD);
`ifdef LCD_SPI_CS_TOGGLE_EN
        chk("pair_cs_high_cycles", cs_high_cnt, GAP);
`else
        chk("pair_cs_high_cycles", cs_high_cnt, 0);
`endif
        $display("txn pair: rx=%0d bytes cs_high_between=%0d", rx_q.size(), cs_high_cnt);

        // Long init stream.
        for (int i = 0; i < NSTREAM; i++) seq_tbl[i] = {(i % 3) != 0, 8'(i * 29 + 3)};
        n0 = wd_count;
        run_stream(NSTREAM);
        repeat (20) @(posedge sys_clk_50MHz);
        #1;
        chk("stream_wr_done_count", wd_count - n0, NSTREAM);
        chk("stream_rx_count", rx_q.size(), NSTREAM);
        for (int i = 0; i < NSTREAM && i < rx_q.size(); i++) begin
            chk("stream_word", int'(rx_q[i]), int'(seq_tbl[i]));
            $display("txn stream %0d: rx=%03h want=%03h", i, rx_q[i], seq_tbl[i]);
        end
`ifdef LCD_SPI_CS_TOGGLE_EN
        chk("stream_cs_high_cycles", cs_high_cnt, GAP * (NSTREAM - 1));
`else
        chk("stream_cs_high_cycles", cs_high_cnt, 0);
`endif

        // Reset asserted during bit 4 of a byte.
        rx_q.delete();
        @(posedge sys_clk_50MHz); #1;
        n0 = wd_count;
        bus.init_data = 9'h1E7;
        bus.en_write  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clk_50MHz); #1;
            if (rx_bits == 4) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reached_bit4", int'(ok), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("midbyte_reset_outputs", int'({lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, bus.wr_done, bus.busy}), 6'b100000);
        repeat (5) @(posedge sys_clk_50MHz);
        #1;
        chk("aborted_no_wr_done", wd_count - n0, 0);
        chk("aborted_no_rx", rx_q.size(), 0);
        bus.init_data = 9'h13C;
        sys_rst_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge sys_clk_50MHz); #1;
            if (bus.wr_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("post_reset_wr_done", int'(ok), 1);
        bus.en_write = 1'b0;
        wait_idle("idle_after_reset_byte");
        chk("post_reset_wr_done_count", wd_count - n0, 1);
        chk("post_reset_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            chk("post_reset_rx", int'(rx_q[0]), 9'h13C);
            $display("txn reset-recovery: rx=%03h", rx_q[0]);
        end

        chk("mosi_stable_while_sclk_high", mosi_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
